ahbl_splitter_n: RTL and testbench

- Parametrised N-port AHB-Lite data-phase splitter and address decoder for the system bus.
- Decodes the top PAGE_BITS of HADDR into one-hot HSEL, then muxes HRDATA/HREADY/HRESP from the data-phase slave.
- Adds an integrated default slave, which returns a spec-compliant two-cycle ERROR for transfers to unmapped pages.
- Adds sticky error-address capture and a saturating error counter for firmware diagnostics.

---
 rtl/ahbl_pkg.sv | 24 ++
 rtl/ahbl_default_slave.sv | 69 ++++++
 rtl/ahbl_splitter_n.sv | 116 +++++++++++
 tb/tb_ahbl_splitter_n.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings for the system-bus splitter and its default slave.
package ahbl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  function automatic logic is_active_xfer(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahbl_default_slave.sv
// Default slave: two-cycle ERROR response for unmapped pages, plus sticky
// first-error address capture and a saturating error counter.
module ahbl_default_slave
  import ahbl_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 hready_i,
  input  logic                 xfer_i,
  input  logic                 hit_i,
  input  logic [31:0]          haddr_i,
  input  logic                 err_clr_i,
  output logic                 ds_hready_o,
  output logic                 ds_hresp_o,
  output logic                 err_valid_o,
  output logic [31:0]          err_addr_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  ds_state_e state_q;
  logic      enter;

  assign enter = hready_i & xfer_i & ~hit_i & (state_q != DS_ERR1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= DS_IDLE;
      ds_hready_o <= 1'b1;
      ds_hresp_o  <= HRESP_OKAY;
      err_valid_o <= 1'b0;
      err_addr_o  <= '0;
      err_cnt_o   <= '0;
    end else begin
      case (state_q)
        DS_ERR1: begin
          state_q     <= DS_ERR2;
          ds_hready_o <= 1'b1;
          ds_hresp_o  <= HRESP_ERROR;
        end
        default: begin
          // DS_ERR2 samples the next address phase exactly like DS_IDLE
          if (enter) begin
            state_q     <= DS_ERR1;
            ds_hready_o <= 1'b0;
            ds_hresp_o  <= HRESP_ERROR;
          end else begin
            state_q     <= DS_IDLE;
            ds_hready_o <= 1'b1;
            ds_hresp_o  <= HRESP_OKAY;
          end
        end
      endcase

      if (enter) begin
        err_valid_o <= 1'b1;
        if (err_clr_i || !err_valid_o) err_addr_o <= haddr_i;
        if (err_clr_i)              err_cnt_o <= ERR_CNT_W'(1);
        else if (err_cnt_o != '1)   err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
      end else if (err_clr_i) begin
        err_valid_o <= 1'b0;
        err_addr_o  <= '0;
        err_cnt_o   <= '0;
      end
    end
  end

endmodule

// File: rtl/ahbl_splitter_n.sv
// N-port AHB-Lite address decoder and data-phase response mux with an
// integrated default slave for unmapped pages.
module ahbl_splitter_n
  import ahbl_pkg::*;
#(
  parameter int unsigned                       NUM_SLAVES    = 5,
  parameter int unsigned                       PAGE_BITS     = 4,
  parameter logic [NUM_SLAVES*PAGE_BITS-1:0]   SLAVE_PAGES   = {4'h6, 4'h5, 4'h4, 4'h2, 4'h0},
  parameter logic [31:0]                       DEFAULT_RDATA = 32'hBADDBEEF,
  parameter int unsigned                       ERR_CNT_W     = 8
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  input  logic [31:0]                HADDR,
  input  logic [1:0]                 HTRANS,
  output logic                       HREADY,
  output logic                       HRESP,
  output logic [31:0]                HRDATA,
  output logic [NUM_SLAVES-1:0]      HSEL,
  input  logic [32*NUM_SLAVES-1:0]   S_HRDATA,
  input  logic [NUM_SLAVES-1:0]      S_HREADYOUT,
  input  logic [NUM_SLAVES-1:0]      S_HRESP,
  input  logic                       ERR_CLR,
  output logic                       ERR_VALID,
  output logic [31:0]                ERR_ADDR,
  output logic [ERR_CNT_W-1:0]       ERR_CNT
);

  logic [NUM_SLAVES-1:0] page_match;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic                  dflt_q, dflt_d;
  logic                  hit, xfer;
  logic                  ds_hready, ds_hresp;
  logic [31:0]           mux_rdata;
  logic                  mux_ready, mux_resp;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_match
    assign page_match[g] = (HADDR[31 -: PAGE_BITS] == SLAVE_PAGES[g*PAGE_BITS +: PAGE_BITS]);
  end

  // Duplicate pages resolve to the lowest index, keeping HSEL at most one-hot
  always_comb begin
    logic taken;
    taken = 1'b0;
    HSEL  = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      HSEL[i] = page_match[i] & ~taken;
      taken   = taken | page_match[i];
    end
  end

  assign hit  = |HSEL;
  assign xfer = is_active_xfer(HTRANS);

  always_comb begin
    sel_d  = sel_q;
    dflt_d = dflt_q;
    if (HREADY) begin
      if (xfer && hit) begin
        sel_d  = HSEL;
        dflt_d = 1'b0;
      end else if (xfer) begin
        sel_d  = '0;
        dflt_d = 1'b1;
      end else begin
        sel_d  = '0;
        dflt_d = 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sel_q  <= '0;
      dflt_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      dflt_q <= dflt_d;
    end
  end

  always_comb begin
    mux_rdata = '0;
    mux_ready = 1'b0;
    mux_resp  = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        mux_rdata = mux_rdata | S_HRDATA[i*32 +: 32];
        mux_ready = mux_ready | S_HREADYOUT[i];
        mux_resp  = mux_resp  | S_HRESP[i];
      end
    end
  end

  assign HRDATA = (|sel_q) ? mux_rdata : DEFAULT_RDATA;
  assign HREADY = (|sel_q) ? mux_ready : (dflt_q ? ds_hready : 1'b1);
  assign HRESP  = (|sel_q) ? mux_resp  : (dflt_q ? ds_hresp  : HRESP_OKAY);

  ahbl_default_slave #(
    .ERR_CNT_W (ERR_CNT_W)
  ) u_dflt (
    .clk_i       (HCLK),
    .rst_i       (HRESET),
    .hready_i    (HREADY),
    .xfer_i      (xfer),
    .hit_i       (hit),
    .haddr_i     (HADDR),
    .err_clr_i   (ERR_CLR),
    .ds_hready_o (ds_hready),
    .ds_hresp_o  (ds_hresp),
    .err_valid_o (ERR_VALID),
    .err_addr_o  (ERR_ADDR),
    .err_cnt_o   (ERR_CNT)
  );

endmodule

// File: tb/tb_ahbl_splitter_n.sv
// Scoreboard bench: stimulus queues expected data-phase responses, a negedge
// monitor tracks AHB data phases and compares on completion.
module tb_ahbl_splitter_n;
  import ahbl_pkg::*;

  logic         HCLK = 1'b0;
  logic         HRESET;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic         HREADY, HRESP;
  logic [31:0]  HRDATA;
  logic [4:0]   HSEL;
  logic [159:0] S_HRDATA;
  logic [4:0]   S_HREADYOUT, S_HRESP;
  logic         ERR_CLR;
  logic         ERR_VALID;
  logic [31:0]  ERR_ADDR;
  logic [7:0]   ERR_CNT;

  logic         HREADY2, HRESP2, ERR_VALID2;
  logic [31:0]  HRDATA2, ERR_ADDR2;
  logic [4:0]   HSEL2;
  logic [1:0]   ERR_CNT2;

  always #5 HCLK = ~HCLK;

  ahbl_splitter_n dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .HSEL(HSEL),
    .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
    .ERR_CLR(ERR_CLR), .ERR_VALID(ERR_VALID), .ERR_ADDR(ERR_ADDR), .ERR_CNT(ERR_CNT)
  );

  // Narrow counter and a duplicated page (slaves 1 and 2 both own page 4)
  ahbl_splitter_n #(
    .SLAVE_PAGES ({4'h6, 4'h5, 4'h4, 4'h4, 4'h0}),
    .ERR_CNT_W   (2)
  ) dut2 (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADY(HREADY2), .HRESP(HRESP2), .HRDATA(HRDATA2), .HSEL(HSEL2),
    .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
    .ERR_CLR(ERR_CLR), .ERR_VALID(ERR_VALID2), .ERR_ADDR(ERR_ADDR2), .ERR_CNT(ERR_CNT2)
  );

  typedef struct {
    string       name;
    int          waits;
    logic        resp1;
    logic        resp;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic push(input string name, input int waits, input logic r1, input logic r,
                      input logic [31:0] d);
    exp_t e;
    e.name = name; e.waits = waits; e.resp1 = r1; e.resp = r; e.rdata = d;
    exp_q.push_back(e);
  endtask

  bit   m_act = 0;
  int   m_cyc = 0;
  logic m_r1  = 1'b0;

  always @(negedge HCLK) begin
    if (HRESET) begin
      m_act = 0;
    end else begin
      if (m_act) begin
        if (m_cyc == 0) m_r1 = HRESP;
        if (HREADY) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_dphase: got resp %b data %h expected none", HRESP, HRDATA);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, "_waits"}, 32'(m_cyc), 32'(e.waits));
            chk({e.name, "_resp1"}, 32'(m_r1), 32'(e.resp1));
            chk({e.name, "_resp"},  32'(HRESP), 32'(e.resp));
            chk({e.name, "_rdata"}, HRDATA, e.rdata);
          end
          m_act = 0;
        end else begin
          m_cyc++;
          if (m_cyc > 16) begin
            n_cmp++; n_bad++;
            $display("FAIL dphase_timeout: got %0d wait cycles expected at most 16", m_cyc);
            m_act = 0;
          end
        end
      end
      if (HREADY && HTRANS[1]) begin
        m_act = 1;
        m_cyc = 0;
      end
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge HCLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    HRESET = 1'b1; HTRANS = HTRANS_IDLE; HADDR = '0; ERR_CLR = 1'b0;
    S_HRDATA = '0; S_HREADYOUT = '1; S_HRESP = '0;
    step(); step();
    HRESET = 1'b0;
    at_neg();
    chk("rst_hready", 32'(HREADY), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, 32'hBADDBEEF);
    chk("rst_err_valid", 32'(ERR_VALID), 32'd0);
    chk("rst_err_cnt", 32'(ERR_CNT), 32'd0);
    chk("rst_err_addr", ERR_ADDR, 32'd0);
    step();

    // Mapped read to slave 2 with two wait states
    HADDR = 32'h4000_0010; HTRANS = HTRANS_NONSEQ;
    push("rd_s2", 2, 1'b0, 1'b0, 32'h1234_5678);
    at_neg();
    chk("rd_hsel", 32'(HSEL), 32'b00100);
    chk("dup_hsel_lowest", 32'(HSEL2), 32'b00010);
    step();
    HTRANS = HTRANS_IDLE; HADDR = '0; S_HREADYOUT = 5'b11011;
    at_neg();
    chk("rd_wait_hready", 32'(HREADY), 32'd0);
    step();
    step();
    S_HREADYOUT = '1; S_HRDATA[2*32 +: 32] = 32'h1234_5678;
    step();

    // Zero-wait access to slave 4 passing through a slave ERROR
    HADDR = 32'h6000_0020; HTRANS = HTRANS_NONSEQ;
    push("s4_err", 0, 1'b1, 1'b1, 32'hCAFE_F00D);
    at_neg();
    chk("s4_hsel", 32'(HSEL), 32'b10000);
    step();
    HTRANS = HTRANS_IDLE; HADDR = '0; S_HRESP = 5'b10000; S_HRDATA[4*32 +: 32] = 32'hCAFE_F00D;
    step();
    S_HRESP = '0;

    // Single unmapped access
    HADDR = 32'hF000_0004; HTRANS = HTRANS_NONSEQ;
    push("unm1", 1, 1'b1, 1'b1, 32'hBADDBEEF);
    at_neg();
    chk("unm_hsel", 32'(HSEL), 32'd0);
    step();
    HTRANS = HTRANS_IDLE; HADDR = '0;
    at_neg();
    chk("err1_hready", 32'(HREADY), 32'd0);
    chk("err1_hresp", 32'(HRESP), 32'd1);
    chk("unm1_err_valid", 32'(ERR_VALID), 32'd1);
    chk("unm1_err_addr", ERR_ADDR, 32'hF000_0004);
    chk("unm1_err_cnt", 32'(ERR_CNT), 32'd1);
    step();
    at_neg();
    chk("err2_hready", 32'(HREADY), 32'd1);
    chk("err2_hresp", 32'(HRESP), 32'd1);
    step();
    at_neg();
    chk("cancel_hready", 32'(HREADY), 32'd1);
    chk("cancel_hresp", 32'(HRESP), 32'd0);
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    at_neg();
    chk("clr_err_valid", 32'(ERR_VALID), 32'd0);
    chk("clr_err_cnt", 32'(ERR_CNT), 32'd0);
    chk("clr_err_addr", ERR_ADDR, 32'd0);
    step();

    // Back-to-back unmapped, second accepted in DS_ERR2
    HADDR = 32'hF000_0000; HTRANS = HTRANS_NONSEQ;
    push("b2b_a", 1, 1'b1, 1'b1, 32'hBADDBEEF);
    push("b2b_b", 1, 1'b1, 1'b1, 32'hBADDBEEF);
    step();
    HADDR = 32'h9000_0000;
    step();
    at_neg();
    chk("b2b_err2_hready", 32'(HREADY), 32'd1);
    chk("b2b_err2_hresp", 32'(HRESP), 32'd1);
    step();
    HTRANS = HTRANS_IDLE; HADDR = '0;
    at_neg();
    chk("b2b_err1_hready", 32'(HREADY), 32'd0);
    step();
    step();
    at_neg();
    chk("b2b_err_addr", ERR_ADDR, 32'hF000_0000);
    chk("b2b_err_cnt", 32'(ERR_CNT), 32'd2);
    chk("b2b_idle_hresp", 32'(HRESP), 32'd0);
    step();

    // Clear coincident with a new unmapped access
    HADDR = 32'hA000_0000; HTRANS = HTRANS_NONSEQ; ERR_CLR = 1'b1;
    push("clr_new", 1, 1'b1, 1'b1, 32'hBADDBEEF);
    step();
    ERR_CLR = 1'b0; HTRANS = HTRANS_IDLE; HADDR = '0;
    at_neg();
    chk("clrnew_err_valid", 32'(ERR_VALID), 32'd1);
    chk("clrnew_err_addr", ERR_ADDR, 32'hA000_0000);
    chk("clrnew_err_cnt", 32'(ERR_CNT), 32'd1);
    step();
    step();

    // BUSY to an unmapped page is not an error
    HADDR = 32'hF000_0000; HTRANS = HTRANS_BUSY;
    step();
    HTRANS = HTRANS_IDLE; HADDR = '0;
    at_neg();
    chk("busy_hready", 32'(HREADY), 32'd1);
    chk("busy_hresp", 32'(HRESP), 32'd0);
    chk("busy_err_cnt", 32'(ERR_CNT), 32'd1);
    step();

    // Reset while in DS_ERR1 aborts the response
    HADDR = 32'hF000_0008; HTRANS = HTRANS_NONSEQ;
    step();
    HTRANS = HTRANS_IDLE; HADDR = '0; HRESET = 1'b1;
    at_neg();
    chk("pre_rst_err1_hready", 32'(HREADY), 32'd0);
    step();
    HRESET = 1'b0;
    at_neg();
    chk("abort_hready", 32'(HREADY), 32'd1);
    chk("abort_hresp", 32'(HRESP), 32'd0);
    chk("abort_err_valid", 32'(ERR_VALID), 32'd0);
    chk("abort_err_cnt", 32'(ERR_CNT), 32'd0);
    step();

    // Five back-to-back unmapped accesses: narrow counter saturates
    HADDR = 32'hE000_0000; HTRANS = HTRANS_NONSEQ;
    for (int k = 0; k < 5; k++) push("sat", 1, 1'b1, 1'b1, 32'hBADDBEEF);
    repeat (9) step();
    HTRANS = HTRANS_IDLE; HADDR = '0;
    step();
    step();
    at_neg();
    chk("sat_cnt8", 32'(ERR_CNT), 32'd5);
    chk("sat_cnt2", 32'(ERR_CNT2), 32'd3);
    chk("sat_err_addr", ERR_ADDR, 32'hE000_0000);
    chk("sat_err_valid2", 32'(ERR_VALID2), 32'd1);

    repeat (3) step();
    chk("sb_pending", 32'(exp_q.size()), 32'd0);
    chk("mon_idle", 32'(m_act), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
